// File: rtl/imem_loader_server_pkg.sv
// Shared types and defaults for the instruction memory / program loader slice.
package imem_pkg;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_FINISH  = 2'd3
    } load_state_t;

    localparam int          ADDR_W_DEFAULT   = 10;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Even parity: the stored bit makes the 33-bit codeword have an even number of ones.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_loader_server_if.sv
// Fetch read port and byte-stream load port between fetch unit / boot source and the memory server.
interface imem_loader_server_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic [31:0]     fetch_addr;
    logic [31:0]     instruction;
    logic            fetch_err;
    logic            load_mode;
    logic            load_byte_valid;
    logic [7:0]      load_byte;
    logic            load_byte_ready;
    logic            load_done;
    logic [ADDR_W:0] load_word_count;
    logic            load_ovf;
    logic            parity_err;
    logic            cpu_hold;

    modport master (
        output fetch_addr, load_mode, load_byte_valid, load_byte,
        input  instruction, fetch_err, load_byte_ready, load_done,
               load_word_count, load_ovf, parity_err, cpu_hold
    );

    modport slave (
        input  fetch_addr, load_mode, load_byte_valid, load_byte,
        output instruction, fetch_err, load_byte_ready, load_done,
               load_word_count, load_ovf, parity_err, cpu_hold
    );
endinterface

// File: rtl/imem_loader_server_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses the cycle after the 4th byte.
module imem_byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete,
    output logic        word_valid
);
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic [7:0]  lane_d [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_d[gi] = (byte_en && idx_q == 2'(gi)) ? byte_in : word_q[gi*8 +: 8];
    end

    always_comb begin
        idx_d        = idx_q;
        word_d       = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
        word_valid_d = 1'b0;
        if (clear) begin
            idx_d = 2'd0;
        end else if (byte_en) begin
            idx_d        = idx_q + 2'd1;
            word_valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q        <= 2'd0;
            word_q       <= 32'h0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word          = word_q;
    assign word_complete = byte_en & ~clear & (idx_q == 2'd3);
    assign word_valid    = word_valid_q;
endmodule

// File: rtl/imem_loader_server.sv
// Word-addressed instruction memory with a byte-stream program loader that owns it while the CPU is held.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_loader_server
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    imem_loader_server_if.slave bus
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    load_state_t     state_q, state_d;
    logic [ADDR_W:0] word_count_q, word_count_d;
    logic            load_ovf_q, load_ovf_d;
    logic            fetch_err_q, fetch_err_d;
    logic            nop_sel_q, nop_sel_d;

    logic            asm_clear, byte_en, word_complete, word_valid;
    logic [31:0]     asm_word;
    logic            mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       rd_data_q;
    logic [ADDR_W-1:0] rd_idx;
    logic              addr_err, rd_en, cpu_hold;

    // A byte offered in the cycle load_mode drops is deliberately not taken.
    assign byte_en = bus.load_byte_valid & bus.load_mode & (state_q == LD_COLLECT);

    imem_byte_assembler u_asm (
        .clk           (clock),
        .reset         (reset),
        .clear         (asm_clear),
        .byte_en       (byte_en),
        .byte_in       (bus.load_byte),
        .word          (asm_word),
        .word_complete (word_complete),
        .word_valid    (word_valid)
    );

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        load_ovf_d   = load_ovf_q;
        asm_clear    = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            LD_IDLE: begin
                if (bus.load_mode) begin
                    state_d      = LD_COLLECT;
                    word_count_d = '0;
                    load_ovf_d   = 1'b0;
                    asm_clear    = 1'b1;
                end
            end
            LD_COLLECT: begin
                if (!bus.load_mode)    state_d = LD_FINISH;
                else if (word_complete) state_d = LD_WRITE;
            end
            LD_WRITE: begin
                // Counter saturates at full depth so word 0 is never overwritten.
                if (word_valid) begin
                    if (word_count_q < DEPTH_CNT) begin
                        mem_we       = reset;
                        word_count_d = word_count_q + 1'b1;
                    end else begin
                        load_ovf_d = 1'b1;
                    end
                end
                state_d = bus.load_mode ? LD_COLLECT : LD_FINISH;
            end
            LD_FINISH: state_d = LD_IDLE;
            default:   state_d = LD_IDLE;
        endcase
    end

    assign mem_waddr = word_count_q[ADDR_W-1:0];
    assign rd_idx    = bus.fetch_addr[ADDR_W+1:2];
    assign addr_err  = (|bus.fetch_addr[1:0]) | (|bus.fetch_addr[31:ADDR_W+2]);
    assign cpu_hold  = bus.load_mode | (state_q != LD_IDLE);
    assign rd_en     = ~cpu_hold & ~addr_err;

    always_comb begin
        fetch_err_d = ~cpu_hold & addr_err;
        nop_sel_d   = ~rd_en;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= LD_IDLE;
            word_count_q <= '0;
            load_ovf_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            nop_sel_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            load_ovf_q   <= load_ovf_d;
            fetch_err_q  <= fetch_err_d;
            nop_sel_q    <= nop_sel_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= asm_word;
    end

    always_ff @(posedge clock) begin
        if (rd_en) rd_data_q <= mem_q[rd_idx];
    end

`ifdef IMEM_PARITY_EN
    logic par_mem_q [DEPTH];
    logic par_rd_q;

    always_ff @(posedge clock) begin
        if (mem_we) par_mem_q[mem_waddr] <= even_parity(asm_word);
    end

    always_ff @(posedge clock) begin
        if (rd_en) par_rd_q <= par_mem_q[rd_idx];
    end

    assign bus.parity_err = ~nop_sel_q & (even_parity(rd_data_q) ^ par_rd_q);
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.instruction     = nop_sel_q ? NOP_WORD : rd_data_q;
    assign bus.fetch_err       = fetch_err_q;
    assign bus.load_byte_ready = (state_q == LD_COLLECT);
    assign bus.load_done       = (state_q == LD_FINISH);
    assign bus.load_word_count = word_count_q;
    assign bus.load_ovf        = load_ovf_q;
    assign bus.cpu_hold        = cpu_hold;
endmodule

// File: tb/tb_imem_loader_server.sv
// Scoreboarded bench: one full-depth instance (ADDR_W=10) and one tiny instance (ADDR_W=2) for overflow.
module tb_imem_loader_server;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_a = 0;
    int   done_b = 0;
    logic [31:0] exp_q [$];

    imem_loader_server_if #(.ADDR_W(10)) bus_a ();
    imem_loader_server_if #(.ADDR_W(2))  bus_b ();

    imem_loader_server #(.ADDR_W(10), .NOP_WORD(32'h0)) dut_a (.clock(clk), .reset(rst_n), .bus(bus_a));
    imem_loader_server #(.ADDR_W(2),  .NOP_WORD(32'h0)) dut_b (.clock(clk), .reset(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_a.load_done === 1'b1) done_a <= done_a + 1;
        if (bus_b.load_done === 1'b1) done_b <= done_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input bit on_b, input logic v);
        if (on_b) bus_b.load_mode = v;
        else      bus_a.load_mode = v;
    endtask

    task automatic send_byte(input bit on_b, input logic [7:0] b);
        bit   ok;
        logic rdy;
        ok = 1'b0;
        bus_a.load_byte_valid = 1'b1; bus_a.load_byte = b;
        bus_b.load_byte_valid = 1'b1; bus_b.load_byte = b;
        for (int c = 0; c < 20; c++) begin
            rdy = on_b ? bus_b.load_byte_ready : bus_a.load_byte_ready;
            tick();
            if (rdy === 1'b1) begin ok = 1'b1; break; end
        end
        bus_a.load_byte_valid = 1'b0;
        bus_b.load_byte_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_byte_timeout: ready got 0 want 1 within 20 cycles");
        end
    endtask

    task automatic send_word(input bit on_b, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(on_b, w[8*i +: 8]);
    endtask

    task automatic start_load(input bit on_b);
        set_mode(on_b, 1'b1);
        tick();
    endtask

    task automatic end_load(input bit on_b);
        bit ok;
        ok = 1'b0;
        set_mode(on_b, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if ((on_b ? bus_b.cpu_hold : bus_a.cpu_hold) === 1'b0) begin ok = 1'b1; break; end
        end
        tick();
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL end_load_timeout: cpu_hold got 1 want 0 within 10 cycles");
        end
    endtask

    task automatic fetch(input bit on_b, input logic [31:0] addr,
                         output logic [31:0] instr, output logic err);
        bus_a.fetch_addr = addr;
        bus_b.fetch_addr = addr;
        tick();
        instr = on_b ? bus_b.instruction : bus_a.instruction;
        err   = on_b ? bus_b.fetch_err   : bus_a.fetch_err;
        $display("fetch %s addr=%08h instr=%08h err=%0b", on_b ? "B" : "A", addr, instr, err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.fetch_addr = 32'h0; bus_a.load_mode = 1'b0; bus_a.load_byte_valid = 1'b0; bus_a.load_byte = 8'h0;
        bus_b.fetch_addr = 32'h0; bus_b.load_mode = 1'b0; bus_b.load_byte_valid = 1'b0; bus_b.load_byte = 8'h0;
        tick(); tick();
        vectors++; if (bus_a.instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", bus_a.instruction); end
        vectors++; if (bus_a.fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_err: got %b want 0", bus_a.fetch_err); end
        vectors++; if (bus_a.load_byte_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", bus_a.load_byte_ready); end
        vectors++; if (bus_a.load_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus_a.load_done); end
        vectors++; if (bus_a.load_word_count !== 11'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus_a.load_word_count); end
        vectors++; if (bus_a.load_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", bus_a.load_ovf); end
        vectors++; if (bus_a.parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity: got %b want 0", bus_a.parity_err); end
        vectors++; if (bus_b.load_word_count !== 3'd0) begin miscompares++; $display("FAIL reset_count_b: got %0d want 0", bus_b.load_word_count); end
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_load();
        int d0;
        logic [31:0] instr, w;
        logic err;
        start_load(1'b0);
        vectors++; if (bus_a.cpu_hold !== 1'b1 || bus_a.instruction !== 32'h0) begin
            miscompares++; $display("FAIL load_hold: hold=%b instr=%h want hold=1 instr=00000000", bus_a.cpu_hold, bus_a.instruction);
        end
        d0 = done_a;
        send_word(1'b0, 32'h1234_5678); exp_q.push_back(32'h1234_5678);
        send_word(1'b0, 32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
        end_load(1'b0);
        vectors++; if (done_a - d0 !== 1) begin miscompares++; $display("FAIL load_done_pulses: got %0d want 1", done_a - d0); end
        vectors++; if (bus_a.load_word_count !== 11'd2) begin miscompares++; $display("FAIL load_count: got %0d want 2", bus_a.load_word_count); end
        for (int i = 0; i < 2; i++) begin
            w = exp_q.pop_front();
            fetch(1'b0, 32'(i * 4), instr, err);
            vectors++; if (instr !== w || err !== 1'b0) begin
                miscompares++; $display("FAIL load_readback[%0d]: got %h err=%b want %h err=0", i, instr, err, w);
            end
        end
    endtask

    task automatic test_fetch_err();
        logic [31:0] instr;
        logic err;
        fetch(1'b0, 32'h4, instr, err);
        vectors++; if (instr !== 32'hDEAD_BEEF || err !== 1'b0) begin miscompares++; $display("FAIL fetch_4: got %h err=%b want deadbeef err=0", instr, err); end
        fetch(1'b0, 32'h6, instr, err);
        vectors++; if (instr !== 32'h0 || err !== 1'b1) begin miscompares++; $display("FAIL fetch_misaligned: got %h err=%b want 00000000 err=1", instr, err); end
        fetch(1'b0, 32'h1000, instr, err);
        vectors++; if (instr !== 32'h0 || err !== 1'b1) begin miscompares++; $display("FAIL fetch_range: got %h err=%b want 00000000 err=1", instr, err); end
        fetch(1'b0, 32'h0, instr, err);
        vectors++; if (instr !== 32'h1234_5678 || err !== 1'b0) begin miscompares++; $display("FAIL fetch_0: got %h err=%b want 12345678 err=0", instr, err); end
    endtask

    task automatic test_overflow();
        int d0;
        logic [31:0] instr, w;
        logic err;
        d0 = done_b;
        start_load(1'b1);
        for (int i = 0; i < 5; i++) begin
            w = 32'hA5A5_0000 | 32'(i * 32'h0101);
            send_word(1'b1, w);
            if (i < 4) exp_q.push_back(w);
        end
        end_load(1'b1);
        vectors++; if (bus_b.load_word_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", bus_b.load_word_count); end
        vectors++; if (bus_b.load_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", bus_b.load_ovf); end
        vectors++; if (done_b - d0 !== 1) begin miscompares++; $display("FAIL ovf_done_pulses: got %0d want 1", done_b - d0); end
        for (int i = 0; i < 4; i++) begin
            w = exp_q.pop_front();
            fetch(1'b1, 32'(i * 4), instr, err);
            vectors++; if (instr !== w || err !== 1'b0) begin
                miscompares++; $display("FAIL ovf_readback[%0d]: got %h err=%b want %h err=0", i, instr, err, w);
            end
        end
        fetch(1'b1, 32'h10, instr, err);
        vectors++; if (err !== 1'b1 || instr !== 32'h0) begin miscompares++; $display("FAIL ovf_range_b: got %h err=%b want 00000000 err=1", instr, err); end
    endtask

    task automatic test_partial();
        int d0;
        logic [31:0] instr, w;
        logic err;
        start_load(1'b0);
        send_word(1'b0, 32'h0BAD_0000); send_word(1'b0, 32'h0BAD_0001); send_word(1'b0, 32'h0BAD_0002);
        end_load(1'b0);
        d0 = done_a;
        start_load(1'b0);
        send_word(1'b0, 32'hC0DE_0010); exp_q.push_back(32'hC0DE_0010);
        send_word(1'b0, 32'hC0DE_0011); exp_q.push_back(32'hC0DE_0011);
        exp_q.push_back(32'h0BAD_0002);
        send_byte(1'b0, 8'h77); send_byte(1'b0, 8'h66);
        end_load(1'b0);
        vectors++; if (bus_a.load_word_count !== 11'd2) begin miscompares++; $display("FAIL partial_count: got %0d want 2", bus_a.load_word_count); end
        vectors++; if (done_a - d0 !== 1) begin miscompares++; $display("FAIL partial_done_pulses: got %0d want 1", done_a - d0); end
        vectors++; if (bus_a.load_ovf !== 1'b0) begin miscompares++; $display("FAIL partial_ovf: got %b want 0", bus_a.load_ovf); end
        for (int i = 0; i < 3; i++) begin
            w = exp_q.pop_front();
            fetch(1'b0, 32'(i * 4), instr, err);
            vectors++; if (instr !== w || err !== 1'b0) begin
                miscompares++; $display("FAIL partial_readback[%0d]: got %h err=%b want %h err=0", i, instr, err, w);
            end
        end
    endtask

    task automatic test_reset_midload();
        int d0;
        logic [31:0] instr, w;
        logic err;
        start_load(1'b0);
        send_word(1'b0, 32'h5EED_0000); exp_q.push_back(32'h5EED_0000);
        exp_q.push_back(32'hC0DE_0011); exp_q.push_back(32'h0BAD_0002);
        send_byte(1'b0, 8'h11); send_byte(1'b0, 8'h22);
        d0 = done_a;
        rst_n = 1'b0;
        bus_a.load_mode = 1'b0;
        tick();
        vectors++; if (bus_a.load_byte_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", bus_a.load_byte_ready); end
        vectors++; if (bus_a.load_word_count !== 11'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", bus_a.load_word_count); end
        rst_n = 1'b1;
        tick(); tick(); tick();
        vectors++; if (done_a - d0 !== 0) begin miscompares++; $display("FAIL rst_no_done: got %0d pulses want 0", done_a - d0); end
        for (int i = 0; i < 3; i++) begin
            w = exp_q.pop_front();
            fetch(1'b0, 32'(i * 4), instr, err);
            vectors++; if (instr !== w || err !== 1'b0) begin
                miscompares++; $display("FAIL rst_mem[%0d]: got %h err=%b want %h err=0", i, instr, err, w);
            end
        end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        logic [31:0] instr;
        logic err;
        fetch(1'b0, 32'h0, instr, err);
        vectors++; if (bus_a.parity_err !== 1'b0) begin miscompares++; $display("FAIL parity_clean: got %b want 0", bus_a.parity_err); end
        dut_a.mem_q[0] = dut_a.mem_q[0] ^ 32'h0000_0100;
        fetch(1'b0, 32'h4, instr, err);
        fetch(1'b0, 32'h0, instr, err);
        vectors++; if (bus_a.parity_err !== 1'b1) begin miscompares++; $display("FAIL parity_flip: got %b want 1", bus_a.parity_err); end
        vectors++; if (instr !== 32'h5EED_0100) begin miscompares++; $display("FAIL parity_data: got %h want 5eed0100", instr); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_fetch_err();
        test_overflow();
        test_partial();
        test_reset_midload();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
